branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised, registered successor to the combinational branch comparator. Evaluates the RV32I branch condition and computes the resolved next PC, taken flag and mispredict flag against the fetch-stage prediction, over a one-stage valid/ready pipeline register. Sits at the EX/MEM boundary, feeding the PC-redirect logic and hazard/flush control. Keeps saturating branch and mispredict performance counters.

Parameters:
XLEN, 32, operand/PC width in bits (minimum 8)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
is_branch  in  1  conditional branch (func3 selects the condition)
is_jump  in  1  unconditional jump (JAL/JALR target already in pc+imm form)
func3  in  3  branch condition encoding
rs1  in  XLEN  operand A
rs2  in  XLEN  operand B
pc  in  XLEN  PC of the instruction
imm  in  XLEN  sign-extended offset
pred_taken  in  1  fetch-stage prediction
flush  in  1  kill the in-flight entry and any request arriving this cycle
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
taken  out  1  resolved direction
target  out  XLEN  resolved next PC
mispredict  out  1  taken != pred_taken
illegal  out  1  is_branch with a reserved func3
branch_cnt  out  CNT_W  completed branch/jump count
mispred_cnt  out  CNT_W  completed mispredict count

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, taken=0, target=0, mispredict=0, illegal=0, branch_cnt=0, mispred_cnt=0. Release is synchronous to clk through the normal flop path.
- in_ready = !out_valid || out_ready (combinational, single entry, no bubble when the stream flows).
- Accept = in_valid && in_ready && !flush. On accept, register the results; out_valid=1 on the next edge. Latency is 1 cycle.
- While out_valid && !out_ready, all outputs hold stable.
- When out_valid && out_ready && no new accept, out_valid goes to 0.
- Flush has priority over everything: on the next edge out_valid=0, and any same-cycle request is dropped. Counters are not updated for a flushed entry.
- Condition decode when is_branch=1:
  - 000: equal
  - 001: not equal
  - 100: signed less than
  - 101: signed greater or equal
  - 110: unsigned less than
  - 111: unsigned greater or equal
  - 010 and 011: taken=0, illegal=1.
- is_jump=1: taken=1, regardless of is_branch and func3. illegal=0.
- Neither is_branch nor is_jump: taken=0, illegal=0.
- target = taken ? pc+imm : pc+4. Sum is XLEN bits and wraps modulo 2^XLEN; no overflow flag.
- mispredict = taken ^ pred_taken. This applies to non-branch and illegal entries too.
- Counters update only on an output handshake (out_valid && out_ready):
  - branch_cnt +1 if the entry was a branch or jump.
  - mispred_cnt +1 if mispredict=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Simultaneous output handshake and flush: the handshaken entry counts; any new request is dropped.

Test Plan:
- BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20, pred_taken=0, out_ready=1 -> one cycle later out_valid=1, taken=1, target=0x120, mispredict=1, mispred_cnt=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1. BLTU with the same operands -> taken=0, target=pc+4. BGEU 0x80000000 vs 0x7FFFFFFF -> taken=1.
- func3=010 with is_branch=1, pred_taken=1 -> illegal=1, taken=0, mispredict=1.
- Back-pressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, outputs stable. Then out_ready=1 -> a back-to-back stream completes at 1 result per cycle.
- flush asserted with an entry pending and a new in_valid -> next cycle out_valid=0, counters unchanged. pc=0xFFFFFFFC, imm=8, jump -> target=0x4 (wrap).
- CNT_W=2: 5 mispredicted handshakes -> mispred_cnt stays at 3. Assert rst_n low mid-stream, asynchronous to clk -> all outputs zero immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// RV32I branch resolution behind a single-entry valid/ready register.
// Also keeps saturating counters of completed branches and mispredicts.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic [2:0]       func3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic            accept, handshake;
  logic            cond_taken, cond_illegal;
  logic            res_taken, res_illegal;
  logic [XLEN-1:0] res_target;

  logic             out_valid_q, taken_q, mispredict_q, illegal_q, is_br_q;
  logic [XLEN-1:0]  target_q;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (func3)
      3'b000:  cond_taken = (rs1 == rs2);
      3'b001:  cond_taken = (rs1 != rs2);
      3'b100:  cond_taken = ($signed(rs1) < $signed(rs2));
      3'b101:  cond_taken = ($signed(rs1) >= $signed(rs2));
      3'b110:  cond_taken = (rs1 < rs2);
      3'b111:  cond_taken = (rs1 >= rs2);
      default: cond_illegal = 1'b1;
    endcase
  end

  // A jump overrides whatever func3 says, including reserved encodings.
  always_comb begin
    res_taken   = is_jump || (is_branch && cond_taken);
    res_illegal = is_branch && !is_jump && cond_illegal;
    res_target  = res_taken ? (pc + imm) : (pc + XLEN'(4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      is_br_q      <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        taken_q      <= res_taken;
        target_q     <= res_target;
        mispredict_q <= res_taken ^ pred_taken;
        illegal_q    <= res_illegal;
        is_br_q      <= is_branch || is_jump;
      end
    end
  end

  // Counting on the output handshake means a flushed entry never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (handshake) begin
      if (is_br_q && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
      if (mispredict_q && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign taken       = taken_q;
  assign target      = target_q;
  assign mispredict  = mispredict_q;
  assign illegal     = illegal_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed literal cases, then random traffic
// compared every cycle against a behavioural model.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, is_branch = 1'b0, is_jump = 1'b0, pred_taken = 1'b0;
  logic flush = 1'b0, out_ready = 1'b1;
  logic [2:0] func3 = '0;
  logic [XLEN-1:0] rs1 = '0, rs2 = '0, pc = '0, imm = '0;
  logic in_ready, out_valid, taken, mispredict, illegal;
  logic [XLEN-1:0] target;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jump(is_jump), .func3(func3), .rs1(rs1), .rs2(rs2),
    .pc(pc), .imm(imm), .pred_taken(pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
    .mispredict(mispredict), .illegal(illegal), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: resolve one request from the ISA rules.
  function automatic void resolve(input logic br, input logic jp, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] p, input logic [31:0] i,
                                  output logic tk, output logic ill,
                                  output logic [31:0] tgt);
    logic [32:0] sum;
    tk  = 1'b0;
    ill = 1'b0;
    if (jp) tk = 1'b1;
    else if (br) begin
      if (f3 == 3'd0) tk = (a == b);
      else if (f3 == 3'd1) tk = (a != b);
      else if (f3 == 3'd4) tk = (int'(a) < int'(b));
      else if (f3 == 3'd5) tk = !(int'(a) < int'(b));
      else if (f3 == 3'd6) tk = (a < b);
      else if (f3 == 3'd7) tk = !(a < b);
      else ill = 1'b1;
    end
    sum = tk ? ({1'b0, p} + {1'b0, i}) : ({1'b0, p} + 33'd4);
    tgt = sum[31:0];
  endfunction

  logic m_valid, m_taken, m_misp, m_ill, m_br;
  logic [XLEN-1:0] m_target;
  int m_bcnt, m_mcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_taken <= 1'b0; m_misp <= 1'b0; m_ill <= 1'b0;
      m_br <= 1'b0; m_target <= '0; m_bcnt <= 0; m_mcnt <= 0;
    end else begin
      logic tk, ill;
      logic [31:0] tgt;
      if (m_valid && out_ready) begin
        if (m_br && m_bcnt < CMAX) m_bcnt <= m_bcnt + 1;
        if (m_misp && m_mcnt < CMAX) m_mcnt <= m_mcnt + 1;
      end
      if (flush) m_valid <= 1'b0;
      else if (in_valid && (!m_valid || out_ready)) begin
        resolve(is_branch, is_jump, func3, rs1, rs2, pc, imm, tk, ill, tgt);
        m_valid  <= 1'b1;
        m_taken  <= tk;
        m_ill    <= ill;
        m_target <= tgt;
        m_misp   <= tk ^ pred_taken;
        m_br     <= is_branch || is_jump;
      end else if (m_valid && out_ready) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("taken", taken, m_taken);
        chk("target", target, m_target);
        chk("mispredict", mispredict, m_misp);
        chk("illegal", illegal, m_ill);
      end
      chk("branch_cnt", branch_cnt, m_bcnt);
      chk("mispred_cnt", mispred_cnt, m_mcnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic br, input logic jp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] i, input logic pt);
    in_valid = 1'b1; is_branch = br; is_jump = jp; func3 = f3;
    rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_taken"}, taken, 1'b0);
    chk({tag, "_target"}, target, 32'h0);
    chk({tag, "_mispredict"}, mispredict, 1'b0);
    chk({tag, "_illegal"}, illegal, 1'b0);
    chk({tag, "_branch_cnt"}, branch_cnt, 3'd0);
    chk({tag, "_mispred_cnt"}, mispred_cnt, 3'd0);
  endtask

  initial begin
    #12;
    check_reset_state("rst");
    step();
    rst_n = 1'b1;
    step();

    // BEQ taken, predicted not taken
    issue(1, 0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 0);
    step();
    in_valid = 1'b0;
    chk("beq_valid", out_valid, 1'b1);
    chk("beq_taken", taken, 1'b1);
    chk("beq_target", target, 32'h120);
    chk("beq_misp", mispredict, 1'b1);
    step();
    chk("beq_mcnt", mispred_cnt, 3'd1);

    issue(1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h10, 1);
    step();
    chk("blt_taken", taken, 1'b1);
    chk("blt_target", target, 32'h210);
    issue(1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h10, 1);
    step();
    chk("bltu_taken", taken, 1'b0);
    chk("bltu_target", target, 32'h204);
    issue(1, 0, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 32'hFFFF_FFFC, 1);
    step();
    chk("bgeu_taken", taken, 1'b1);
    chk("bgeu_target", target, 32'h2FC);
    issue(1, 0, 3'b010, 32'h0, 32'h0, 32'h400, 32'h40, 1);
    step();
    in_valid = 1'b0;
    chk("ill_illegal", illegal, 1'b1);
    chk("ill_taken", taken, 1'b0);
    chk("ill_misp", mispredict, 1'b1);
    step();
    chk("cnt5_branch", branch_cnt, 3'd5);
    chk("cnt5_misp", mispred_cnt, 3'd3);

    // Back-pressure then a back-to-back stream
    out_ready = 1'b0;
    issue(0, 1, 3'b000, 32'h0, 32'h0, 32'h400, 32'h40, 1);
    step();
    pc = 32'h500; imm = 32'h10;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_target", target, 32'h440);
      chk("bp_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h500 + 32'(k) * 32'h100;
      step();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_target", target, pc + 32'h10);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", out_valid, 1'b0);
    chk("branch_sat", branch_cnt, 3'd7);

    // Flush with an entry pending and a new request
    out_ready = 1'b0;
    issue(0, 1, 3'b000, 32'h0, 32'h0, 32'h800, 32'h8, 0);
    step();
    pc = 32'h900;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_mcnt", mispred_cnt, 3'd3);

    issue(0, 1, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 1);
    step();
    in_valid = 1'b0;
    chk("wrap_target", target, 32'h4);

    // Five mispredicted non-branch entries saturate the mispredict counter
    issue(0, 0, 3'b000, 32'h0, 32'h0, 32'h1000, 32'h0, 1);
    for (int k = 0; k < 5; k++) step();
    in_valid = 1'b0;
    step();
    step();
    chk("misp_sat", mispred_cnt, 3'd7);

    // Random traffic with asynchronous resets mid-stream
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid   = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 19) == 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      is_branch  = $urandom_range(0, 1);
      is_jump    = ($urandom_range(0, 3) == 0);
      func3      = 3'($urandom_range(0, 7));
      pred_taken = $urandom_range(0, 1);
      rs1        = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
      rs2        = ($urandom_range(0, 2) == 0) ? rs1 : (($urandom_range(0, 1) == 1) ?
                   $urandom : 32'($urandom_range(0, 3)));
      pc         = $urandom;
      imm        = $urandom;
      if (cyc == 700 || cyc == 1400) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
      end
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
